// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and transmitter.
//   uart_state_t   : frame state machine encoding
//   UART_DATA_BITS : data bits per frame (8N1)
//   UART_CNT_W     : width of the bit-period counter (CLKS_PER_BIT up to 65535)
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_CNT_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous RX pin into the i_Clock domain and
// flags a high-to-low transition of the synchronised line.
//   i_Clock     : system clock
//   i_Reset     : asynchronous reset, active-high; all flops reset to idle-high
//   i_Rx_Serial : raw RX pin
//   o_rx_s      : synchronised RX level
//   o_fall      : previous synchronised sample high, current one low
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Rx_Serial,
  output logic o_rx_s,
  output logic o_fall
);

  logic rx_meta_q, rx_meta_d;
  logic rx_s_q,    rx_s_d;
  logic rx_prev_q, rx_prev_d;

  always_comb begin
    rx_meta_d = i_Rx_Serial;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
  end

  // Reset to 1 so that a line already idling high never looks like a start edge.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  assign o_rx_s = rx_s_q;
  assign o_fall = rx_prev_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with mid-bit sampling.
//   i_Clock        : system clock, rising edge
//   i_Reset        : asynchronous reset, active-high
//   i_Rx_Serial    : RX pin, asynchronous, idles high
//   o_Rx_DV        : 1-cycle strobe, o_Rx_Byte holds a freshly received byte
//   o_Rx_Byte      : last good byte, held until the next good byte
//   o_Rx_Frame_Err : 1-cycle strobe, stop bit sampled low and byte discarded
//   o_Rx_Active    : high while a frame is being received
//
// state     | meaning
// S_IDLE    | waiting for a falling edge on the synchronised line
// S_START   | half a bit in, re-check the start bit to reject glitches
// S_DATA    | sample one data bit per full bit period, LSB first
// S_STOP    | sample the stop bit, deliver byte or flag framing error
// S_CLEANUP | one cycle gap before returning to idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam logic [UART_CNT_W-1:0] HALF = UART_CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [UART_CNT_W-1:0] FULL = UART_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]            LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_Serial (i_Rx_Serial),
    .o_rx_s      (rx_s),
    .o_fall      (fall)
  );

  uart_state_t                 state_q,   state_d;
  logic [UART_CNT_W-1:0]       cnt_q,     cnt_d;
  logic [2:0]                  bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]   shift_q,   shift_d;
  logic [UART_DATA_BITS-1:0]   byte_q,    byte_d;
  logic                        dv_q,      dv_d;
  logic                        ferr_q,    ferr_d;

  logic tick_half;
  logic tick_full;

  assign tick_half = (cnt_q == HALF);
  assign tick_full = (cnt_q == FULL);

  // State register and datapath flops.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic. Only a falling edge leaves idle, so a held-low break
  // line cannot re-trigger the receiver.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (fall) state_d = S_START;
      S_START:   if (tick_half) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:    if (tick_full && (bit_idx_q == LAST_BIT)) state_d = S_STOP;
      S_STOP:    if (tick_full) state_d = S_CLEANUP;
      S_CLEANUP: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Counter, bit index, shift register and result strobes.
  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;

    // Counter restarts on every state change and at each data-bit boundary.
    if ((state_d != state_q) || (state_q == S_DATA && tick_full)) begin
      cnt_d = '0;
    end else if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end

    case (state_q)
      S_START: bit_idx_d = '0;
      S_DATA: begin
        if (tick_full) begin
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tick_full) begin
          if (rx_s) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    o_Rx_Active    = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    o_Rx_DV        = dv_q;
    o_Rx_Frame_Err = ferr_q;
    o_Rx_Byte      = byte_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_fast, rx_slow;
  logic       dv_f, ferr_f, act_f;
  logic [7:0] byte_f;
  logic       dv_s, ferr_s, act_s;
  logic [7:0] byte_s;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(8)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (rx_fast),
    .o_Rx_DV        (dv_f),
    .o_Rx_Byte      (byte_f),
    .o_Rx_Frame_Err (ferr_f),
    .o_Rx_Active    (act_f)
  );

  uart_rx #(.CLKS_PER_BIT(234)) dut_slow (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (rx_slow),
    .o_Rx_DV        (dv_s),
    .o_Rx_Byte      (byte_s),
    .o_Rx_Frame_Err (ferr_s),
    .o_Rx_Active    (act_s)
  );

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input int act, input int exp);
    chk_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [7:0] exp_f[$];
  logic [7:0] exp_s[$];
  int         dv_cyc_f[$];
  int         ferr_exp   = 0;
  int         dv_cnt_f   = 0;
  int         ferr_cnt_f = 0;
  int         dv_cnt_s   = 0;
  int         cyc        = 0;
  bit         prev_pulse = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (dv_f || ferr_f) begin
      check_val("dv_ferr_exclusive", int'(dv_f & ferr_f), 0);
      check_val("pulse_spacing", int'(prev_pulse), 0);
    end
    if (dv_f) begin
      dv_cnt_f++;
      dv_cyc_f.push_back(cyc);
      if (exp_f.size() == 0) check_val("dv_expected", int'(exp_f.size() > 0), 1);
      else check_val("rx_byte", int'(byte_f), int'(exp_f.pop_front()));
    end
    if (ferr_f) begin
      ferr_cnt_f++;
      check_val("ferr_expected", int'(ferr_exp > 0), 1);
      if (ferr_exp > 0) ferr_exp--;
    end
    prev_pulse = dv_f | ferr_f;

    if (dv_s) begin
      dv_cnt_s++;
      if (exp_s.size() == 0) check_val("dv_slow_expected", int'(exp_s.size() > 0), 1);
      else check_val("rx_byte_slow", int'(byte_s), int'(exp_s.pop_front()));
    end
    if (ferr_s) check_val("ferr_slow", int'(ferr_s), 0);
  end

  task automatic drive_bit(input int sel, input logic v, input int n);
    if (sel == 0) rx_fast = v;
    else rx_slow = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] b, input logic stop, input int per);
    if (sel == 0) begin
      if (stop) exp_f.push_back(b);
      else ferr_exp++;
    end else if (stop) begin
      exp_s.push_back(b);
    end
    drive_bit(sel, 1'b0, per);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i], per);
    drive_bit(sel, stop, per);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d0, f0, ds0, act_cycles, lat;
    rst     = 1'b1;
    rx_fast = 1'b1;
    rx_slow = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_dv", int'(dv_f), 0);
    check_val("reset_ferr", int'(ferr_f), 0);
    check_val("reset_active", int'(act_f), 0);
    check_val("reset_byte", int'(byte_f), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: single byte, latency and idle afterwards
    d0 = dv_cnt_f; f0 = ferr_cnt_f; t0 = cyc;
    send_frame(0, 8'hA5, 1'b1, 8);
    repeat (8) @(negedge clk);
    check_val("t1_dv_count", dv_cnt_f - d0, 1);
    check_val("t1_ferr_count", ferr_cnt_f - f0, 0);
    check_val("t1_active_after", int'(act_f), 0);
    check_val("t1_byte_held", int'(byte_f), 'hA5);
    if (dv_cyc_f.size() > 0) begin
      lat = dv_cyc_f[dv_cyc_f.size()-1] - t0;
      check_val("t1_latency_in_range", int'(lat >= 77 && lat <= 79), 1);
    end else begin
      check_val("t1_latency_seen", dv_cyc_f.size(), 1);
    end

    // 2: back-to-back frames
    dv_cyc_f.delete();
    d0 = dv_cnt_f;
    send_frame(0, 8'h00, 1'b1, 8);
    send_frame(0, 8'hFF, 1'b1, 8);
    send_frame(0, 8'h3C, 1'b1, 8);
    repeat (20) @(negedge clk);
    check_val("t2_dv_count", dv_cnt_f - d0, 3);
    check_val("t2_queue_empty", exp_f.size(), 0);
    if (dv_cyc_f.size() == 3) begin
      check_val("t2_gap_01", dv_cyc_f[1] - dv_cyc_f[0], 80);
      check_val("t2_gap_12", dv_cyc_f[2] - dv_cyc_f[1], 80);
    end else begin
      check_val("t2_dv_times", dv_cyc_f.size(), 3);
    end

    // 3: 2-clock glitch on idle line
    d0 = dv_cnt_f; f0 = ferr_cnt_f; act_cycles = 0;
    drive_bit(0, 1'b0, 2);
    rx_fast = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (act_f) act_cycles++;
    end
    check_val("t3_active_seen", int'(act_cycles > 0), 1);
    check_val("t3_active_max", int'(act_cycles <= 7), 1);
    check_val("t3_active_end", int'(act_f), 0);
    check_val("t3_dv_count", dv_cnt_f - d0, 0);
    check_val("t3_ferr_count", ferr_cnt_f - f0, 0);

    // 4: framing error followed by a held-low break
    d0 = dv_cnt_f; f0 = ferr_cnt_f; act_cycles = 0;
    send_frame(0, 8'h55, 1'b0, 8);
    rx_fast = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (act_f) act_cycles++;
    end
    rx_fast = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (act_f) act_cycles++;
    end
    check_val("t4_ferr_count", ferr_cnt_f - f0, 1);
    check_val("t4_dv_count", dv_cnt_f - d0, 0);
    check_val("t4_byte_unchanged", int'(byte_f), 'h3C);
    check_val("t4_no_activity", act_cycles, 0);
    check_val("t4_ferr_consumed", ferr_exp, 0);

    // 5: reset during data bit 4 of 8'hC3, then 8'h81
    d0 = dv_cnt_f; f0 = ferr_cnt_f;
    drive_bit(0, 1'b0, 8);
    drive_bit(0, 1'b1, 8);
    drive_bit(0, 1'b1, 8);
    drive_bit(0, 1'b0, 8);
    drive_bit(0, 1'b0, 8);
    drive_bit(0, 1'b0, 4);
    rst     = 1'b1;
    rx_fast = 1'b1;
    repeat (2) @(negedge clk);
    check_val("t5_rst_dv", int'(dv_f), 0);
    check_val("t5_rst_ferr", int'(ferr_f), 0);
    check_val("t5_rst_active", int'(act_f), 0);
    check_val("t5_rst_byte", int'(byte_f), 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(0, 8'h81, 1'b1, 8);
    repeat (10) @(negedge clk);
    check_val("t5_dv_count", dv_cnt_f - d0, 1);
    check_val("t5_ferr_count", ferr_cnt_f - f0, 0);
    check_val("t5_byte", int'(byte_f), 'h81);

    // 6: CLKS_PER_BIT=234 with -3% and +3% bit periods
    ds0 = dv_cnt_s;
    send_frame(1, 8'h96, 1'b1, 227);
    repeat (300) @(negedge clk);
    send_frame(1, 8'h96, 1'b1, 241);
    repeat (300) @(negedge clk);
    check_val("t6_dv_count", dv_cnt_s - ds0, 2);
    check_val("t6_queue_empty", exp_s.size(), 0);
    check_val("t6_active_end", int'(act_s), 0);

    check_val("final_queue_empty", exp_f.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
